bus_arbiter: RTL and testbench

Two-master arbiter in front of the system bridge. It shares the single CPU-side peripheral port (address, write data, byte enables, read data) between master 0, the CPU data port, and master 1, a DMA/loader engine. It grants one master per cycle, supports bounded bus locking for multi-beat sequences, and routes the bridge's one-cycle-late registered read data back to the master that issued the read.

---
 rtl/bus_arbiter_pkg.sv | 30 +++
 rtl/bus_arbiter_arb_pick.sv | 42 ++++
 rtl/bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: owner encoding,
// bus widths and the bundled beat record used by the request muxes.
package bus_arbiter_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int LOCK_CNT_W = 8;
    localparam int NUM_M      = 2;

    // Which master currently holds the bus via lock.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // One bus beat as presented by a master or driven to the bridge.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [BE_W-1:0]   byteen;
    } beat_t;

    // Map a master index (0 = CPU, 1 = DMA) to its owner code.
    function automatic owner_e owner_of(input logic id);
        return id ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// Pure combinational winner select for bus_arbiter. Priority order:
// forced hand-over on lock break, then the requesting lock owner, then the
// tie policy (master other than last wins), then a lone requester.
// Fixed priority is obtained by the parent tying last_i high.
module bus_arbiter_arb_pick
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_M-1:0] req_i,
    input  owner_e           lock_owner_i,
    input  logic             lock_break_i,
    input  logic             last_i,
    output logic [NUM_M-1:0] gnt_o
);

    logic owner_req;

    // Select exactly one winner (or none) from requests and lock state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_o     = '0;
        owner_req = 1'b0;

        if (lock_owner_i == OWN_M0) begin
            owner_req = req_i[0];
        end else if (lock_owner_i == OWN_M1) begin
            owner_req = req_i[1];
        end

        if (lock_break_i) begin
            // The waiting master takes the bus away from the owner.
            gnt_o = (lock_owner_i == OWN_M1) ? 2'b01 : 2'b10;
        end else if (owner_req) begin
            gnt_o = (lock_owner_i == OWN_M1) ? 2'b10 : 2'b01;
        end else if (&req_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the system bridge. Master 0 is the CPU
// data port, master 1 the DMA/loader engine. One beat is granted per
// cycle, a master may hold the bus with lock for at most MAX_LOCK beats
// while the other is waiting, and read data returning one cycle later is
// steered back to the master that issued the read.
//
// Build option: define BUS_ARB_RR_EN for round-robin tie breaking;
// without it master 0 wins every tie (fixed priority).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic [BE_W-1:0]   m0_byteen,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic [BE_W-1:0]   m1_byteen,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] PrAddr,
    output logic [DATA_W-1:0] PrWD,
    output logic [BE_W-1:0]   byteen,
    input  logic [DATA_W-1:0] PrRD
);

    localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

    // Lock ownership and the run length of locked beats under contention.
    owner_e                lock_owner_q, lock_owner_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q,   lock_cnt_d;

    // Outstanding read: set for the cycle after a granted read.
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_id_q,   rd_id_d;

    logic [NUM_M-1:0]      req;
    logic [NUM_M-1:0]      pick_gnt;
    logic [NUM_M-1:0]      gnt;
    logic                  gnt_any;
    logic                  gnt_id;
    logic                  gnt_lock;
    logic                  other_req;
    logic                  lock_break;
    logic                  last;
    logic [LOCK_CNT_W-1:0] cnt_base;

    beat_t                 m0_beat;
    beat_t                 m1_beat;
    beat_t                 bus_beat;

    assign req     = {m1_req, m0_req};
    assign m0_beat = '{addr: m0_addr, wd: m0_wd, byteen: m0_byteen};
    assign m1_beat = '{addr: m1_addr, wd: m1_wd, byteen: m1_byteen};

    // The owner has used up its budget while the other master waits.
    assign lock_break = (lock_owner_q != OWN_NONE) && (&req) &&
                        (lock_cnt_q == MAX_LOCK_C);

`ifdef BUS_ARB_RR_EN
    logic last_q;

    // Remember the most recent winner so the other master wins the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (gnt_any) begin
            last_q <= gnt_id;
        end
    end

    assign last = last_q;
`else
    // Pretending master 1 always went last makes master 0 win every tie.
    assign last = 1'b1;
`endif

    bus_arbiter_arb_pick arb_pick (
        .req_i        (req),
        .lock_owner_i (lock_owner_q),
        .lock_break_i (lock_break),
        .last_i       (last),
        .gnt_o        (pick_gnt)
    );

    // No beat is accepted while reset is held, whatever the masters request.
    assign gnt       = reset ? '0 : pick_gnt;
    assign gnt_any   = |gnt;
    assign gnt_id    = gnt[1];
    assign gnt_lock  = gnt_id ? m1_lock : m0_lock;
    assign other_req = gnt_id ? req[0] : req[1];

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Next lock state and read-tracking state from this cycle's grant.
    always_comb begin
        lock_owner_d = OWN_NONE;
        lock_cnt_d   = '0;
        cnt_base     = '0;

        // A locked grant keeps (or takes) ownership unless it came from a
        // lock break; any other outcome releases the bus.
        if (gnt_any && gnt_lock && !lock_break) begin
            lock_owner_d = owner_of(gnt_id);
            // A new owner starts counting from zero.
            if (lock_owner_q == owner_of(gnt_id)) begin
                cnt_base = lock_cnt_q;
            end
            // Only beats taken while the other master waits count.
            if (other_req) begin
                lock_cnt_d = (cnt_base == MAX_LOCK_C) ? cnt_base
                                                      : cnt_base + LOCK_CNT_W'(1);
            end
        end

        rd_pend_d = gnt_any && (bus_beat.byteen == '0);
        rd_id_d   = gnt_id;
    end

    // State registers; reset also drops a read that is still in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the values
        // from before the edge, independent of statement order.
        if (reset) begin
            lock_owner_q <= OWN_NONE;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_id_q      <= 1'b0;
        end else begin
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_id_q      <= rd_id_d;
        end
    end

    // Drive the granted master's beat to the bridge; all zero when idle so
    // the bridge never sees a stray write.
    always_comb begin
        bus_beat = '0;
        if (gnt[0]) begin
            bus_beat = m0_beat;
        end else if (gnt[1]) begin
            bus_beat = m1_beat;
        end
    end

    assign PrAddr = bus_beat.addr;
    assign PrWD   = bus_beat.wd;
    assign byteen = bus_beat.byteen;

    // Return read data only to the master that issued the read; gating with
    // reset suppresses a completion that would land in the reset cycle.
    assign m0_rvalid = rd_pend_q && !rd_id_q && !reset;
    assign m1_rvalid = rd_pend_q &&  rd_id_q && !reset;
    assign m0_rdata  = m0_rvalid ? PrRD : '0;
    assign m1_rdata  = m1_rvalid ? PrRD : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// lock/reset/tie sequences, then random traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int MAX_LOCK = 3;
`ifdef BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] PrAddr, PrWD, PrRD;
    logic [3:0]  byteen;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_byteen(m0_byteen), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_byteen(m1_byteen), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .PrAddr(PrAddr), .PrWD(PrWD), .byteen(byteen), .PrRD(PrRD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // owner: -1 none, else master index; run: locked beats taken while the
    // other master waited; pend: master owed read data this cycle, or -1.
    int m_owner = -1;
    int m_run   = 0;
    int m_last  = 1;
    int m_pend  = -1;
    int m_win   = -1;
    bit m_brk   = 1'b0;

    task automatic model_check();
        bit          rq[2];
        logic [3:0]  be[2];
        logic [31:0] ad[2], wd[2];
        logic [1:0]  e_gnt, e_rv;
        logic [67:0] e_bus;
        rq[0] = m0_req;    rq[1] = m1_req;
        be[0] = m0_byteen; be[1] = m1_byteen;
        ad[0] = m0_addr;   ad[1] = m1_addr;
        wd[0] = m0_wd;     wd[1] = m1_wd;
        m_win = -1;
        m_brk = 1'b0;
        if (!reset) begin
            if (m_owner >= 0 && rq[m_owner]) begin
                if (m_run == MAX_LOCK && rq[1-m_owner]) begin
                    m_win = 1 - m_owner;
                    m_brk = 1'b1;
                end else begin
                    m_win = m_owner;
                end
            end else if (rq[0] && rq[1]) begin
                m_win = RR ? 1 - m_last : 0;
            end else if (rq[0]) begin
                m_win = 0;
            end else if (rq[1]) begin
                m_win = 1;
            end
        end
        e_gnt = (m_win == 0) ? 2'b01 : (m_win == 1) ? 2'b10 : 2'b00;
        e_rv  = (reset || m_pend < 0) ? 2'b00 : (m_pend == 0) ? 2'b01 : 2'b10;
        e_bus = (m_win < 0) ? 68'd0 : {ad[m_win], wd[m_win], be[m_win]};
        check("model_gnt",    {m1_gnt, m0_gnt}, e_gnt);
        check("model_rvalid", {m1_rvalid, m0_rvalid}, e_rv);
        check("model_rdata0", m0_rdata, e_rv[0] ? PrRD : 32'd0);
        check("model_rdata1", m1_rdata, e_rv[1] ? PrRD : 32'd0);
        check("model_bus",    {PrAddr, PrWD, byteen}, e_bus);
    endtask

    task automatic model_update();
        bit         rq[2], lk[2];
        logic [3:0] be[2];
        rq[0] = m0_req;    rq[1] = m1_req;
        lk[0] = m0_lock;   lk[1] = m1_lock;
        be[0] = m0_byteen; be[1] = m1_byteen;
        if (reset) begin
            m_owner = -1; m_run = 0; m_last = 1; m_pend = -1;
        end else begin
            m_pend = (m_win >= 0 && be[m_win] == 4'h0) ? m_win : -1;
            if (m_win >= 0 && lk[m_win] && !m_brk) begin
                if (m_owner != m_win) m_run = 0;
                m_owner = m_win;
                m_run   = rq[1-m_win] ? ((m_run < MAX_LOCK) ? m_run + 1 : MAX_LOCK) : 0;
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
            if (m_win >= 0) m_last = m_win;
        end
    endtask

    // Inputs change at posedge+1; outputs are checked at the negedge.
    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        m0_req = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wd = '0; m0_byteen = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wd = '0; m1_byteen = '0;
        PrRD = '0;
    endtask

    // Two reset cycles with both masters requesting: nothing may be granted.
    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h55; m1_addr = 32'h66;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("reset_gnt",    {m1_gnt, m0_gnt}, 2'b00);
            check("reset_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
            check("reset_praddr", PrAddr, 32'd0);
            advance();
        end
        idle_inputs();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        req0, req1;
        logic [31:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] prrd;
        logic [1:0]  e_gnt, e_rv;
        logic [31:0] e_rd0, e_rd1, e_addr;
        logic [3:0]  e_be;
    } vec_t;

    function automatic vec_t mk(logic r0, logic [31:0] a0, logic [3:0] be0,
                                logic r1, logic [31:0] a1, logic [3:0] be1,
                                logic [31:0] prrd, logic [1:0] e_gnt, logic [1:0] e_rv,
                                logic [31:0] e_rd0, logic [31:0] e_rd1,
                                logic [31:0] e_addr, logic [3:0] e_be);
        vec_t v;
        v.req0 = r0; v.a0 = a0; v.be0 = be0;
        v.req1 = r1; v.a1 = a1; v.be1 = be1;
        v.prrd = prrd; v.e_gnt = e_gnt; v.e_rv = e_rv;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_addr = e_addr; v.e_be = e_be;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e_gnt;

        //            r0 a0          be0   r1 a1          be1   PrRD          gnt    rv     rd0           rd1           addr          be
        tbl[0] = mk(1, 32'h7f00, 4'h0, 0, 32'h0,    4'h0, 32'h0,        2'b01, 2'b00, 32'h0,        32'h0,        32'h7f00, 4'h0);
        tbl[1] = mk(0, 32'h0,    4'h0, 0, 32'h0,    4'h0, 32'h12345678, 2'b00, 2'b01, 32'h12345678, 32'h0,        32'h0,    4'h0);
        tbl[2] = mk(1, 32'h10,   4'h0, 0, 32'h0,    4'h0, 32'h0,        2'b01, 2'b00, 32'h0,        32'h0,        32'h10,   4'h0);
        tbl[3] = mk(0, 32'h0,    4'h0, 1, 32'h7f60, 4'h0, 32'haaaa0001, 2'b10, 2'b01, 32'haaaa0001, 32'h0,        32'h7f60, 4'h0);
        tbl[4] = mk(0, 32'h0,    4'h0, 0, 32'h0,    4'h0, 32'hbbbb0002, 2'b00, 2'b10, 32'h0,        32'hbbbb0002, 32'h0,    4'h0);
        tbl[5] = mk(1, 32'h20,   4'hf, 1, 32'h30,   4'h0, 32'h0,        2'b01, 2'b00, 32'h0,        32'h0,        32'h20,   4'hf);
        tbl[6] = mk(0, 32'h0,    4'h0, 1, 32'h30,   4'h0, 32'hcccc0000, 2'b10, 2'b00, 32'h0,        32'h0,        32'h30,   4'h0);
        tbl[7] = mk(1, 32'h40,   4'h0, 0, 32'h0,    4'h0, 32'hdddd0003, 2'b01, 2'b10, 32'h0,        32'hdddd0003, 32'h40,   4'h0);
        tbl[8] = mk(0, 32'h0,    4'h0, 0, 32'h0,    4'h0, 32'heeee0004, 2'b00, 2'b01, 32'heeee0004, 32'h0,        32'h0,    4'h0);

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset_dut();

        // Single read, back-to-back reads, tie and pipelined completions.
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            m0_req = tbl[i].req0; m0_addr = tbl[i].a0; m0_byteen = tbl[i].be0; m0_wd = ~tbl[i].a0;
            m1_req = tbl[i].req1; m1_addr = tbl[i].a1; m1_byteen = tbl[i].be1; m1_wd = ~tbl[i].a1;
            PrRD = tbl[i].prrd;
            sample();
            check($sformatf("vec%0d_gnt", i),    {m1_gnt, m0_gnt}, tbl[i].e_gnt);
            check($sformatf("vec%0d_rvalid", i), {m1_rvalid, m0_rvalid}, tbl[i].e_rv);
            check($sformatf("vec%0d_rdata0", i), m0_rdata, tbl[i].e_rd0);
            check($sformatf("vec%0d_rdata1", i), m1_rdata, tbl[i].e_rd1);
            check($sformatf("vec%0d_praddr", i), PrAddr, tbl[i].e_addr);
            check($sformatf("vec%0d_byteen", i), byteen, tbl[i].e_be);
            advance();
        end

        // Both masters write every cycle without lock.
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            m0_req = 1'b1; m0_addr = 32'h100 + i; m0_byteen = 4'h3; m0_wd = 32'hA0 + i;
            m1_req = 1'b1; m1_addr = 32'h200 + i; m1_byteen = 4'hc; m1_wd = 32'hB0 + i;
            e_gnt = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
            sample();
            check($sformatf("tie%0d_gnt", i), {m1_gnt, m0_gnt}, e_gnt);
            check($sformatf("tie%0d_byteen", i), byteen, e_gnt[1] ? 4'hc : 4'h3);
            advance();
        end

        // M1 locked burst; M0 starts requesting after the first beat.
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h300 + i; m1_byteen = 4'hf;
            m0_req = (i != 0); m0_addr = 32'h400 + i; m0_byteen = 4'h1;
            if (i < 4)       e_gnt = 2'b10;
            else if (i == 4) e_gnt = 2'b01;
            else             e_gnt = RR ? 2'b10 : 2'b01;
            sample();
            check($sformatf("lock%0d_gnt", i), {m1_gnt, m0_gnt}, e_gnt);
            advance();
        end

        // Read granted in cycle 5, reset in cycle 6.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            PrRD = 32'h13579bdf + i;
            if (i == 5) begin m0_req = 1'b1; m0_addr = 32'h7f00; end
            if (i == 6) begin reset = 1'b1; m0_req = 1'b1; m0_addr = 32'h7f04; end
            sample();
            if (i == 5) check("rst_read_gnt", {m1_gnt, m0_gnt}, 2'b01);
            if (i >= 6) begin
                check($sformatf("rst%0d_rvalid", i), {m1_rvalid, m0_rvalid}, 2'b00);
                check($sformatf("rst%0d_outs", i),
                      {m0_gnt, m1_gnt, m0_rdata, m1_rdata, PrAddr, PrWD, byteen}, '0);
            end
            advance();
        end

        // Random traffic against the model.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            m0_req    = ($urandom_range(0, 3) != 0);
            m1_req    = ($urandom_range(0, 3) != 0);
            m0_lock   = ($urandom_range(0, 3) != 0);
            m1_lock   = ($urandom_range(0, 3) != 0);
            m0_addr   = $urandom;
            m1_addr   = $urandom;
            m0_wd     = $urandom;
            m1_wd     = $urandom;
            m0_byteen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            m1_byteen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            PrRD      = $urandom;
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
